binario_bcd_seq: RTL and testbench
==================================

BINARIO_BCD_SEQ -- requirements
Module: binario_bcd_seq

Interface
REQ-001 SHALL have parameter BIN_W, default 8, meaning width of the binary input (legal 4..20).
REQ-002 SHALL have parameter NDIG, default 3, meaning number of BCD output digits; legal only if 10^NDIG > 2^BIN_W - 1.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port inicio  input  1  start request; sampled only in IDLE.
REQ-006 SHALL have port binario  input  BIN_W  unsigned value to convert; sampled with inicio.
REQ-007 SHALL have port ocupado  output  1  high while a conversion is in progress.
REQ-008 SHALL have port pronto  output  1  one-cycle pulse marking a new result on bcd.
REQ-009 SHALL have port bcd  output  4*NDIG  packed BCD result; digit i (units = 0) on bits [4i+3:4i].
REQ-010 SHALL have port apagar  output  NDIG  leading-zero blank mask; present only when the Configuration macro is defined.

Function
REQ-011 SHALL implement the shift-and-add-3 (double-dabble) algorithm, one binary bit per clock.
REQ-012 SHALL have FSM states IDLE, CONV, FIM; reset state IDLE.
REQ-013 IDLE: on inicio=1, latch binario into an internal shift register, clear the BCD scratch register, load bit counter with BIN_W, go to CONV.
REQ-014 CONV: each cycle, add 3 to every scratch digit >= 5, then shift {scratch, shift register} left one bit, decrement the counter; after the BIN_W-th shift go to FIM.
REQ-015 FIM: copy scratch to bcd, assert pronto for exactly this cycle, return to IDLE.
REQ-016 Latency: inicio sampled at edge k gives pronto=1 and valid bcd in the cycle after edge k+BIN_W+1; throughput is one conversion per BIN_W+2 cycles.
REQ-017 ocupado SHALL be 1 in CONV and FIM, 0 in IDLE.
REQ-018 inicio SHALL be ignored in CONV and FIM; a request held high through FIM is accepted on the first IDLE cycle.
REQ-019 Changes on binario after acceptance SHALL NOT affect the running conversion.
REQ-020 bcd SHALL hold the previous result through CONV and update only at entry to FIM.
REQ-021 Every output digit SHALL be in 0..9; input 0 yields all-zero bcd; input 2^BIN_W-1 yields its exact decimal value.

Reset
REQ-022 rst_n=0 at a rising edge SHALL force IDLE, bcd=0, pronto=0, ocupado=0, apagar=all ones except bit 0, and clear the counter and scratch register, including mid-conversion.
REQ-023 The first inicio after rst_n returns to 1 SHALL be accepted normally, with no result from an aborted conversion ever appearing.

Configuration
REQ-024 Macro BINARIO_BCD_APAGAR_EN, when defined, SHALL add port apagar, registered and updated together with bcd in FIM.
REQ-025 Blank mask rule: apagar[i]=1 iff digit i and all higher digits are zero, for i >= 1; apagar[0] always 0, so the units digit is never blanked.
REQ-026 Without BINARIO_BCD_APAGAR_EN, port apagar and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-027 BIN_W=8, NDIG=3: inicio with binario=8'd255 -> pronto after 10 cycles, bcd=12'h255, apagar=3'b000.
REQ-028 BIN_W=5, NDIG=2: exhaustive sweep of 0..31 -> each bcd equals decimal value (e.g., 31 -> 8'h31, 19 -> 8'h19, 0 -> 8'h00).
REQ-029 BIN_W=8: inicio held high continuously with binario=7 -> conversions every 10 cycles, bcd=12'h007, apagar=3'b110, pronto one cycle wide.
REQ-030 BIN_W=8: start with 200, change binario to 99 one cycle later, pulse inicio during CONV -> single result 12'h200, no second pronto.
REQ-031 BIN_W=8: start with 128, assert rst_n=0 four cycles later -> next cycle bcd=0, ocupado=0, no pronto; new start with 42 -> bcd=12'h042.
REQ-032 BIN_W=16, NDIG=5: binario=65535 -> pronto after 18 cycles, bcd=20'h65535.

Source files
------------

// File: rtl/binario_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// Optional leading-zero blank mask output enabled by macro BINARIO_BCD_APAGAR_EN.
module binario_bcd_seq #(
  parameter int BIN_W = 8,
  parameter int NDIG  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inicio,
  input  logic [BIN_W-1:0]    binario,
  output logic                ocupado,
  output logic                pronto,
  output logic [4*NDIG-1:0]   bcd
`ifdef BINARIO_BCD_APAGAR_EN
  ,
  output logic [NDIG-1:0]     apagar
`endif
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int SW    = 4 * NDIG + BIN_W;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FIM
  } state_t;

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    shift_q, shift_d;
  logic [4*NDIG-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*NDIG-1:0]   bcd_q, bcd_d;
  logic                pronto_q, pronto_d;
  logic [4*NDIG-1:0]   adj;
  logic [SW-1:0]       shifted;

`ifdef BINARIO_BCD_APAGAR_EN
  logic [NDIG-1:0]     apagar_q, apagar_d;
  logic [NDIG-1:0]     blank;

  // A digit is blanked only when it and every more significant digit are zero.
  always_comb begin : blankMask
    logic zeroAbove;
    blank     = '0;
    zeroAbove = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      zeroAbove = zeroAbove & (scratch_q[4*i +: 4] == 4'd0);
      blank[i]  = zeroAbove;
    end
  end

  assign apagar = apagar_q;
`endif

  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < NDIG; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {adj, shift_q} << 1;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    pronto_d  = 1'b0;
`ifdef BINARIO_BCD_APAGAR_EN
    apagar_d  = apagar_q;
`endif
    case (state_q)
      IDLE: begin
        if (inicio) begin
          shift_d   = binario;
          scratch_d = '0;
          cnt_d     = CNT_W'(BIN_W);
          state_d   = CONV;
        end
      end
      CONV: begin
        {scratch_d, shift_d} = shifted;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIM;
        end
      end
      FIM: begin
        // Result and pulse are registered here, so they appear on the first IDLE cycle.
        bcd_d    = scratch_q;
        pronto_d = 1'b1;
`ifdef BINARIO_BCD_APAGAR_EN
        apagar_d = blank;
`endif
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      pronto_q  <= 1'b0;
`ifdef BINARIO_BCD_APAGAR_EN
      apagar_q  <= {{(NDIG-1){1'b1}}, 1'b0};
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      pronto_q  <= pronto_d;
`ifdef BINARIO_BCD_APAGAR_EN
      apagar_q  <= apagar_d;
`endif
    end
  end

  assign ocupado = (state_q != IDLE);
  assign pronto  = pronto_q;
  assign bcd     = bcd_q;

endmodule

// File: tb/tb_binario_bcd_seq.sv
// Scoreboard bench for binario_bcd_seq: three instances (8/3, 5/2, 16/5) checked
// against a decimal-arithmetic reference model; apagar checked when BINARIO_BCD_APAGAR_EN is set.
module tb_binario_bcd_seq;

  typedef struct {
    logic [19:0] bcd;
    logic [4:0]  apa;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cycle = 0;
  int   nCompared = 0;
  int   nMismatched = 0;

  logic        iniA, ocuA, proA;
  logic [7:0]  binA;
  logic [11:0] bcdA;
  logic        iniB, ocuB, proB;
  logic [4:0]  binB;
  logic [7:0]  bcdB;
  logic        iniC, ocuC, proC;
  logic [15:0] binC;
  logic [19:0] bcdC;
`ifdef BINARIO_BCD_APAGAR_EN
  logic [2:0]  apaA;
  logic [1:0]  apaB;
  logic [4:0]  apaC;
`endif

  exp_t qA[$];
  exp_t qB[$];
  exp_t qC[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  binario_bcd_seq #(.BIN_W(8), .NDIG(3)) dutA (
    .clk(clk), .rst_n(rst_n), .inicio(iniA), .binario(binA),
    .ocupado(ocuA), .pronto(proA), .bcd(bcdA)
`ifdef BINARIO_BCD_APAGAR_EN
    , .apagar(apaA)
`endif
  );

  binario_bcd_seq #(.BIN_W(5), .NDIG(2)) dutB (
    .clk(clk), .rst_n(rst_n), .inicio(iniB), .binario(binB),
    .ocupado(ocuB), .pronto(proB), .bcd(bcdB)
`ifdef BINARIO_BCD_APAGAR_EN
    , .apagar(apaB)
`endif
  );

  binario_bcd_seq #(.BIN_W(16), .NDIG(5)) dutC (
    .clk(clk), .rst_n(rst_n), .inicio(iniC), .binario(binC),
    .ocupado(ocuC), .pronto(proC), .bcd(bcdC)
`ifdef BINARIO_BCD_APAGAR_EN
    , .apagar(apaC)
`endif
  );

  // Reference: decimal digits by repeated division, blank mask from powers of ten.
  function automatic logic [19:0] refBcd(input int v);
    logic [19:0] r = '0;
    int x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] refBlank(input int v, input int nd);
    logic [4:0] m = '0;
    int p = 10;
    for (int i = 1; i < nd; i++) begin
      m[i] = (v < p);
      p = p * 10;
    end
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic waitIdle(input int which);
    int g = 0;
    logic busy;
    busy = (which == 0) ? ocuA : (which == 1) ? ocuB : ocuC;
    while (busy !== 1'b0 && g < 200) begin
      @(negedge clk);
      g++;
      busy = (which == 0) ? ocuA : (which == 1) ? ocuB : ocuC;
    end
    if (g >= 200) checkOutput("idle timeout", 32'(busy), 32'd0);
  endtask

  // Issue one start request on the selected instance and enqueue its expected result.
  task automatic applyStimulus(input int which, input int v);
    exp_t e;
    @(negedge clk);
    waitIdle(which);
    case (which)
      0: begin iniA = 1'b1; binA = 8'(v); end
      1: begin iniB = 1'b1; binB = 5'(v); end
      default: begin iniC = 1'b1; binC = 16'(v); end
    endcase
    @(negedge clk);
    e.bcd = refBcd(v);
    case (which)
      0: begin
        iniA = 1'b0; e.apa = refBlank(v, 3); e.due = cycle + 9; qA.push_back(e);
        checkOutput("A busy after start", 32'(ocuA), 32'd1);
      end
      1: begin
        iniB = 1'b0; e.apa = refBlank(v, 2); e.due = cycle + 6; qB.push_back(e);
        checkOutput("B busy after start", 32'(ocuB), 32'd1);
      end
      default: begin
        iniC = 1'b0; e.apa = refBlank(v, 5); e.due = cycle + 17; qC.push_back(e);
        checkOutput("C busy after start", 32'(ocuC), 32'd1);
      end
    endcase
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (proA) begin
      if (qA.size() == 0) checkOutput("A spurious pronto", 32'(proA), 32'd0);
      else begin
        e = qA.pop_front();
        checkOutput("A bcd", 32'(bcdA), 32'(e.bcd));
        checkOutput("A latency", 32'(cycle), 32'(e.due));
`ifdef BINARIO_BCD_APAGAR_EN
        checkOutput("A apagar", 32'(apaA), 32'(e.apa));
`endif
      end
    end
    if (proB) begin
      if (qB.size() == 0) checkOutput("B spurious pronto", 32'(proB), 32'd0);
      else begin
        e = qB.pop_front();
        checkOutput("B bcd", 32'(bcdB), 32'(e.bcd));
        checkOutput("B latency", 32'(cycle), 32'(e.due));
`ifdef BINARIO_BCD_APAGAR_EN
        checkOutput("B apagar", 32'(apaB), 32'(e.apa));
`endif
      end
    end
    if (proC) begin
      if (qC.size() == 0) checkOutput("C spurious pronto", 32'(proC), 32'd0);
      else begin
        e = qC.pop_front();
        checkOutput("C bcd", 32'(bcdC), 32'(e.bcd));
        checkOutput("C latency", 32'(cycle), 32'(e.due));
`ifdef BINARIO_BCD_APAGAR_EN
        checkOutput("C apagar", 32'(apaC), 32'(e.apa));
`endif
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    checkOutput("watchdog expired", 32'd1, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    int e0;
    int g;
    exp_t e;
    rst_n = 1'b0;
    iniA = 1'b0; binA = '0;
    iniB = 1'b0; binB = '0;
    iniC = 1'b0; binC = '0;
    repeat (3) @(negedge clk);
    checkOutput("A reset bcd", 32'(bcdA), 32'd0);
    checkOutput("A reset ocupado", 32'(ocuA), 32'd0);
    checkOutput("A reset pronto", 32'(proA), 32'd0);
    checkOutput("C reset bcd", 32'(bcdC), 32'd0);
`ifdef BINARIO_BCD_APAGAR_EN
    checkOutput("A reset apagar", 32'(apaA), 32'h6);
`endif
    rst_n = 1'b1;

    applyStimulus(0, 255);
    applyStimulus(0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, int'($urandom_range(0, 255)));

    // Input changes and a stray start during conversion must not disturb the 200 result.
    applyStimulus(0, 200);
    binA = 8'd99;
    repeat (2) @(negedge clk);
    iniA = 1'b1;
    @(negedge clk);
    iniA = 1'b0;

    // Held start: back-to-back conversions every BIN_W+2 cycles.
    @(negedge clk);
    waitIdle(0);
    iniA = 1'b1;
    binA = 8'd7;
    e0 = cycle + 1;
    for (int j = 0; j < 3; j++) begin
      e.bcd = refBcd(7);
      e.apa = refBlank(7, 3);
      e.due = e0 + 9 + 10 * j;
      qA.push_back(e);
    end
    while (cycle < e0 + 20) @(negedge clk);
    iniA = 1'b0;

    // Reset in mid-conversion: the aborted 128 must never appear.
    @(negedge clk);
    waitIdle(0);
    iniA = 1'b1;
    binA = 8'd128;
    @(negedge clk);
    iniA = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("A abort bcd", 32'(bcdA), 32'd0);
    checkOutput("A abort ocupado", 32'(ocuA), 32'd0);
    checkOutput("A abort pronto", 32'(proA), 32'd0);
`ifdef BINARIO_BCD_APAGAR_EN
    checkOutput("A abort apagar", 32'(apaA), 32'h6);
`endif
    rst_n = 1'b1;
    applyStimulus(0, 42);

    for (int v = 0; v < 32; v++) applyStimulus(1, v);

    applyStimulus(2, 65535);
    applyStimulus(2, 0);
    for (int i = 0; i < 6; i++) applyStimulus(2, int'($urandom_range(0, 65535)));

    g = 0;
    while ((qA.size() + qB.size() + qC.size()) != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    repeat (30) @(negedge clk);
    checkOutput("pending results", 32'(qA.size() + qB.size() + qC.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
